// File: rtl/loader_pkg.sv
// Shared types and default sizing for the boot-time program loader.
package loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NWORDS = 32;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; flags the 4th byte.
module word_packer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] byte_cnt;

    assign word_valid = take && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (take) begin
            word[8*byte_cnt +: 8] <= in_byte;
            byte_cnt              <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into memory words 0.. while holding the core stalled,
// then hands the memory port over to the core.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NWORDS = DEF_NWORDS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_end,
    output logic              run,
    input  logic              p_W,
    input  logic [31:0]       p_addr,
    input  logic [31:0]       p_dout,
    output logic              m_W,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_dout,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NWORDS - 1);

    state_t          state;
    logic [ADDR_W:0] word_cnt;
    logic            end_pend;
    logic [31:0]     word;
    logic            word_valid;
    logic            take;
    logic            clear;
    logic            unused_addr_bits;

    assign take             = in_valid && in_ready && (state == LOAD);
    // A partial word is dropped when an early end arrives without a 4th byte.
    assign clear            = (state == LOAD) && load_end && !word_valid;
    assign done             = run;
    assign unused_addr_bits = ^p_addr[31:ADDR_W];

    word_packer u_packer (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .take       (take),
        .in_byte    (in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= LOAD;
            word_cnt <= '0;
            end_pend <= 1'b0;
            in_ready <= 1'b1;
            run      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (word_valid) begin
                        state    <= WRITE;
                        end_pend <= load_end;
                        in_ready <= 1'b0;
                    end else if (load_end) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        run      <= 1'b1;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt == LAST || end_pend) begin
                        state    <= DONE;
                        run      <= 1'b1;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= DONE;
                    in_ready <= 1'b0;
                    run      <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        m_W    = 1'b0;
        m_addr = '0;
        m_dout = '0;
        case (state)
            WRITE: begin
                m_W    = 1'b1;
                m_addr = word_cnt[ADDR_W-1:0];
                m_dout = word;
            end
            DONE: begin
                m_W    = p_W;
                m_addr = p_addr[ADDR_W-1:0];
                m_dout = p_dout;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with NWORDS=2, ADDR_W=5.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        load_end;
    logic        run;
    logic        p_W;
    logic [31:0] p_addr;
    logic [31:0] p_dout;
    logic        m_W;
    logic [4:0]  m_addr;
    logic [31:0] m_dout;
    logic        done;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;

    prog_loader #(.ADDR_W(5), .NWORDS(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .load_end (load_end),
        .run      (run),
        .p_W      (p_W),
        .p_addr   (p_addr),
        .p_dout   (p_dout),
        .m_W      (m_W),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (m_W && !run) nwrites++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        in_valid = 1'b0;
        load_end = 1'b0;
        tick();
        resetn = 1'b1;
        nwrites = 0;
    endtask

    // Leaves the DUT in WRITE with in_valid low; end_on_last asserts load_end with the 4th byte.
    task automatic send_word(input logic [31:0] w, input bit gap, input bit end_on_last);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            in_byte  = v[8*i +: 8];
            in_valid = 1'b1;
            load_end = end_on_last && (i == 3);
            tick();
            in_valid = 1'b0;
            load_end = 1'b0;
            if (gap && i < 3) begin
                chk("gap_ready", {31'd0, in_ready}, 32'd1);
                tick();
            end
        end
    endtask

    initial begin
        in_byte = 8'h00;
        p_W = 1'b1;
        p_addr = 32'h0000_0013;
        p_dout = 32'hCAFE_F00D;

        // Reset state; core inputs must be ignored while loading.
        do_reset();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_run",   {31'd0, run},      32'd0);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_mW",    {31'd0, m_W},      32'd0);
        chk("rst_maddr", {27'd0, m_addr},   32'd0);
        chk("rst_mdout", m_dout,            32'd0);

        // Two back-to-back words.
        send_word(32'h4433_2211, 1'b0, 1'b0);
        chk("w0_mW",    {31'd0, m_W},    32'd1);
        chk("w0_addr",  {27'd0, m_addr}, 32'd0);
        chk("w0_data",  m_dout,          32'h4433_2211);
        chk("w0_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("l1_ready", {31'd0, in_ready}, 32'd1);
        chk("l1_mW",    {31'd0, m_W},      32'd0);
        send_word(32'h8877_6655, 1'b0, 1'b0);
        chk("w1_addr", {27'd0, m_addr}, 32'd1);
        chk("w1_data", m_dout,          32'h8877_6655);
        chk("w1_run",  {31'd0, run},    32'd0);
        tick();
        chk("d_run",   {31'd0, run},      32'd1);
        chk("d_done",  {31'd0, done},     32'd1);
        chk("d_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_nwr",  nwrites,           32'd2);

        // Pass-through in DONE is combinational.
        p_W = 1'b1; p_addr = 32'h0000_001F; p_dout = 32'hDEAD_BEEF;
        #1;
        chk("pt_mW",   {31'd0, m_W},    32'd1);
        chk("pt_addr", {27'd0, m_addr}, 32'd31);
        chk("pt_data", m_dout,          32'hDEAD_BEEF);
        p_W = 1'b0; p_addr = 32'h0000_0025; p_dout = 32'h1234_5678;
        #1;
        chk("pt2_mW",   {31'd0, m_W},    32'd0);
        chk("pt2_addr", {27'd0, m_addr}, 32'd5);
        chk("pt2_data", m_dout,          32'h1234_5678);
        p_W = 1'b1;

        // Gaps in in_valid between every byte.
        do_reset();
        send_word(32'h4433_2211, 1'b1, 1'b0);
        chk("g0_addr", {27'd0, m_addr}, 32'd0);
        chk("g0_data", m_dout,          32'h4433_2211);
        tick();
        send_word(32'h8877_6655, 1'b1, 1'b0);
        chk("g1_addr", {27'd0, m_addr}, 32'd1);
        chk("g1_data", m_dout,          32'h8877_6655);
        tick();
        chk("g_run", {31'd0, run}, 32'd1);

        // Three bytes then early end: partial word is dropped.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_byte = 8'hA0 + 8'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("e_run",   {31'd0, run},      32'd1);
        chk("e_ready", {31'd0, in_ready}, 32'd0);
        chk("e_nwr",   nwrites,           32'd0);
        in_valid = 1'b1; in_byte = 8'h55;
        tick(); tick(); tick(); tick();
        in_valid = 1'b0;
        chk("e_hold_run", {31'd0, run}, 32'd1);
        chk("e_hold_nwr", nwrites,      32'd0);

        // load_end together with the 4th byte: word written, then DONE.
        do_reset();
        send_word(32'h0403_0201, 1'b0, 1'b1);
        chk("ew_mW",   {31'd0, m_W},    32'd1);
        chk("ew_addr", {27'd0, m_addr}, 32'd0);
        chk("ew_data", m_dout,          32'h0403_0201);
        chk("ew_run",  {31'd0, run},    32'd0);
        tick();
        chk("ew_done", {31'd0, run}, 32'd1);
        chk("ew_nwr",  nwrites,      32'd1);

        // Reset mid-word restarts at address 0 with a clean buffer.
        do_reset();
        in_valid = 1'b1;
        in_byte = 8'h99; tick();
        in_byte = 8'h98; tick();
        in_valid = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mr_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_run",   {31'd0, run},      32'd0);
        send_word(32'hDDCC_BBAA, 1'b0, 1'b0);
        chk("mr_addr", {27'd0, m_addr}, 32'd0);
        chk("mr_data", m_dout,          32'hDDCC_BBAA);
        tick();
        chk("mr_ready2", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader between the `proc` core and the `memory` block. After reset it accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. It writes those words into `memory` at consecutive word addresses starting from 0, holding the core stalled with `run` low. Once loading is done it raises `run` and passes the core's memory-side signals (`W`, `realaddr`, `dout`) straight through to `memory`.

## Interface
- `ADDR_W`, default 5: memory word-address width; matches `memory`'s `realaddr[4:0]`.
- `NWORDS`, default 32: words loaded before automatic completion; legal range 1..2^ADDR_W.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  one clock; reset is synchronous and active-low.
- `in_byte`  in  8  program byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `load_end`  in  1  single-cycle request to finish loading early.
- `run`  out  1  drives the core's `run`; low while loading.
- `p_W`  in  1  core write enable.
- `p_addr`  in  32  core `realaddr`.
- `p_dout`  in  32  core write data.
- `m_W`  out  1  to memory `W`.
- `m_addr`  out  ADDR_W  to memory `realaddr`.
- `m_dout`  out  32  to memory `dout`.
- `done`  out  1  loading complete; same as `run`.

## Operation
- States: LOAD, WRITE, DONE. Reset enters LOAD with `byte_cnt`=0, `word_cnt`=0 and the word buffer cleared.
- LOAD:
  - `in_ready`=1.
  - A byte transfers when `in_valid` and `in_ready` are both high.
  - Byte k (k = `byte_cnt`) goes to buffer bits [8k+7:8k], so the first byte lands in [7:0].
  - On the 4th byte, `byte_cnt` wraps to 0 and the state moves to WRITE.
- WRITE (exactly one cycle):
  - Outputs `m_W`=1, `m_addr`=`word_cnt`, `m_dout`=buffer; `in_ready`=0.
  - Next state is DONE if `word_cnt`==NWORDS-1 or an early end is pending; otherwise LOAD.
  - `word_cnt` increments on leaving WRITE.
- `load_end` high in LOAD:
  - With no byte completing a word that cycle: go to DONE. Any partial word (`byte_cnt`≠0) is discarded and never written.
  - In the same cycle as a 4th byte: the byte is accepted, the state goes to WRITE, and a pending-end flag makes WRITE exit to DONE.
  - `load_end` is ignored in WRITE and DONE.
- DONE:
  - `run`=`done`=1; `in_ready`=0.
  - Combinational pass-through: `m_W`=`p_W`, `m_addr`=`p_addr[ADDR_W-1:0]`, `m_dout`=`p_dout`.
  - DONE is left only by reset.
- In LOAD and WRITE the core inputs are ignored. Outside WRITE and DONE: `m_W`=0, `m_addr`=0, `m_dout`=0.
- `word_cnt` is ADDR_W+1 bits wide so NWORDS=2^ADDR_W terminates without aliasing.

## Timing
- Reset values (cycle after `resetn` is sampled low): `in_ready`=1, `run`=0, `done`=0, `m_W`=0, `m_addr`=0, `m_dout`=0.
- Latency from accepting a word's 4th byte to its memory write is 1 cycle: the write occurs during WRITE, committed at the next edge by `memory`.
- Throughput is at most 4 bytes per 5 cycles.
- `run` rises the cycle after the final WRITE, or the cycle after an accepted `load_end`.
- Reset mid-load returns to LOAD with counters at 0 and `run`=0; memory contents already written are not cleared.
- `in_valid` may drop between bytes; `byte_cnt` holds.

## Structure
- Shared package `loader_pkg`: state enum (LOAD, WRITE, DONE) and the default NWORDS/ADDR_W constants.
- One sub-module, `word_packer`: byte counter plus 32-bit shift/insert buffer. It outputs `word_valid` on the 4th byte and has a clear input used on reset and on early end.
- The top-level FSM and the DONE pass-through mux live in `prog_loader`, instantiated in `top` between `core0` and `mem0`.

## Test plan
- NWORDS=2; bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 -> write 0x44332211 at addr 0, then 0x88776655 at addr 1; `run` rises 1 cycle after the second WRITE.
- Gaps in `in_valid` between every byte -> same words written; `byte_cnt` holds across the gaps.
- 3 bytes followed by `load_end` -> no write; DONE next cycle; `run`=1.
- `load_end` together with a word's 4th byte -> that word is written, then DONE.
- In DONE, core drives `p_W`=1, `p_addr`=0x1F, `p_dout`=0xDEADBEEF -> `m_W`=1, `m_addr`=31, `m_dout`=0xDEADBEEF in the same cycle.
- `resetn` low mid-word (after 2 bytes) -> next cycle LOAD, `run`=0, `in_ready`=1; the next 4 bytes are written to addr 0.
